// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and parity modes.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } uart_state_e;

    localparam int PAR_EVEN = 0;
    localparam int PAR_ODD  = 1;

    // Parity bit that a correct frame carries for the given payload (zero-extended).
    function automatic logic parity_of(input logic [8:0] payload, input int mode);
        return (^payload) ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Both stages start at the line's idle level so reset never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_gen.sv
// UART receiver: start/data/parity/stop framing with mid-bit sampling,
// a one-cycle data_valid pulse and a one-cycle frame_err pulse.
module uart_rx_gen
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic              sck,
    input  logic              rst_n,
    input  logic              RX,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err
);

    localparam int CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W    = $clog2(DATA_W);
    localparam int HALF     = (CLKS_PER_BIT - 1) / 2;
    localparam int PAR_MODE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

    // The cycle that detects the falling edge is already the first cycle of
    // the start bit, so the start check fires HALF cycles after the edge.
    // With HALF = 0 the detection cycle itself is the start sample.
    localparam bit              SKIP_START = (HALF == 0);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'((HALF > 0) ? HALF - 1 : 0);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_W - 1);

    logic              rxs;
    uart_state_e       state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [IDX_W-1:0]  idx, idx_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic              perr_q, perr_n;
    logic [DATA_W-1:0] dout_n;
    logic              dv_n, pe_n, fe_n;
    logic              bit_done;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk   (sck),
        .rst_n (rst_n),
        .d     (RX),
        .q     (rxs)
    );

    assign bit_done = (cnt == BIT_LAST);

    // State register plus all datapath registers and the registered output pulses.
    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '0;
            perr_q     <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            shreg      <= shreg_n;
            perr_q     <= perr_n;
            data_out   <= dout_n;
            data_valid <= dv_n;
            parity_err <= pe_n;
            frame_err  <= fe_n;
        end
    end

    // Next-state and datapath decisions; every sample point is a single compare on cnt.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shreg_n = shreg;
        perr_n  = perr_q;
        dout_n  = data_out;
        dv_n    = 1'b0;
        pe_n    = 1'b0;
        fe_n    = 1'b0;

        case (state)
            IDLE: begin
                if (!rxs) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    perr_n  = 1'b0;
                    state_n = SKIP_START ? DATA : START;
                end
            end

            START: begin
                if (cnt == START_LAST) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = rxs ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end

            DATA: begin
                if (bit_done) begin
                    cnt_n   = '0;
                    shreg_n = {rxs, shreg[DATA_W-1:1]};
                    if (idx == IDX_LAST) begin
                        state_n = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end

            PARITY: begin
                if (bit_done) begin
                    cnt_n   = '0;
                    perr_n  = (rxs != parity_of(9'(shreg), PAR_MODE));
                    state_n = STOP;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end

            STOP: begin
                if (bit_done) begin
                    cnt_n = '0;
                    if (rxs) begin
                        dout_n  = shreg;
                        dv_n    = 1'b1;
                        pe_n    = (PARITY_EN != 0) ? perr_q : 1'b0;
                        state_n = IDLE;
                    end else begin
                        fe_n    = 1'b1;
                        state_n = WAIT_HIGH;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end

            WAIT_HIGH: begin
                if (rxs) begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                idx_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_gen.sv
// Bench for uart_rx_gen: four instances (CPB 4, CPB 1, CPB 4 with even parity,
// CPB 16) driven with directed and random frames and checked against a frame-level model.
module tb_uart_rx_gen;

    logic       sck = 1'b0;
    logic       rst_n;
    logic [3:0] rx;

    wire [7:0] dout [4];
    wire [3:0] dv;
    wire [3:0] pe;
    wire [3:0] fe;

    int total = 0;
    int bad   = 0;

    int cpb_tab [4] = '{4, 1, 4, 16};
    bit par_tab [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    // Observed output events.
    logic [7:0] got_data [4][$];
    logic       got_pe   [4][$];
    int         fe_seen  [4] = '{default: 0};
    int         stray_pe [4] = '{default: 0};

    // Model expectations.
    logic [7:0] exp_data [4][$];
    logic       exp_pe   [4][$];
    int         exp_fe   [4] = '{default: 0};
    logic [7:0] last_good [4] = '{default: 8'h00};

    always #5 sck = ~sck;

    uart_rx_gen #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0)) dut_c4 (
        .sck(sck), .rst_n(rst_n), .RX(rx[0]), .data_out(dout[0]),
        .data_valid(dv[0]), .parity_err(pe[0]), .frame_err(fe[0]));

    uart_rx_gen #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0), .PARITY_ODD(0)) dut_c1 (
        .sck(sck), .rst_n(rst_n), .RX(rx[1]), .data_out(dout[1]),
        .data_valid(dv[1]), .parity_err(pe[1]), .frame_err(fe[1]));

    uart_rx_gen #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) dut_par (
        .sck(sck), .rst_n(rst_n), .RX(rx[2]), .data_out(dout[2]),
        .data_valid(dv[2]), .parity_err(pe[2]), .frame_err(fe[2]));

    uart_rx_gen #(.DATA_W(8), .CLKS_PER_BIT(16), .PARITY_EN(0), .PARITY_ODD(0)) dut_c16 (
        .sck(sck), .rst_n(rst_n), .RX(rx[3]), .data_out(dout[3]),
        .data_valid(dv[3]), .parity_err(pe[3]), .frame_err(fe[3]));

    // Record every cycle of data_valid / frame_err, and parity_err outside data_valid.
    always @(negedge sck) begin
        for (int i = 0; i < 4; i++) begin
            if (dv[i]) begin
                got_data[i].push_back(dout[i]);
                got_pe[i].push_back(pe[i]);
            end else if (pe[i]) begin
                stray_pe[i]++;
            end
            if (fe[i]) fe_seen[i]++;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int which, input logic b, input int cycles);
        rx[which] = b;
        repeat (cycles) @(negedge sck);
    endtask

    task automatic make_frame(input logic [7:0] d, input bit par_en, input bit par_flip,
                              input logic stop, output logic bits [$]);
        logic pbit;
        bits = {};
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (par_en) begin
            pbit = (($countones(d) % 2) == 1);
            bits.push_back(pbit ^ par_flip);
        end
        bits.push_back(stop);
    endtask

    // Frame-level model: decode the bit list the way a UART receiver should.
    task automatic model_frame(input int which, input logic bits [$]);
        logic [7:0] d;
        logic       pbad;
        int         stop_pos;
        stop_pos = par_tab[which] ? 10 : 9;
        if (bits.size() <= stop_pos || bits[0] !== 1'b0) return;
        for (int i = 0; i < 8; i++) d[i] = bits[i + 1];
        pbad = par_tab[which] && (bits[9] != (($countones(d) % 2) == 1));
        if (bits[stop_pos]) begin
            exp_data[which].push_back(d);
            exp_pe[which].push_back(pbad);
            last_good[which] = d;
        end else begin
            exp_fe[which]++;
        end
    endtask

    task automatic apply_stimulus(input int which, input logic bits [$]);
        foreach (bits[i]) drive(which, bits[i], cpb_tab[which]);
        rx[which] = 1'b1;
        model_frame(which, bits);
    endtask

    task automatic settle(input int which);
        repeat (3 * cpb_tab[which] + 6) @(negedge sck);
    endtask

    task automatic check_dut(input int which, input string name);
        int n;
        check_output({name, "_count"}, got_data[which].size(), exp_data[which].size());
        n = (got_data[which].size() < exp_data[which].size()) ? got_data[which].size()
                                                              : exp_data[which].size();
        for (int i = 0; i < n; i++) begin
            check_output($sformatf("%s_data%0d", name, i), got_data[which][i], exp_data[which][i]);
            check_output($sformatf("%s_perr%0d", name, i), got_pe[which][i], exp_pe[which][i]);
        end
        check_output({name, "_frame_err"}, fe_seen[which], exp_fe[which]);
        check_output({name, "_stray_perr"}, stray_pe[which], 0);
        check_output({name, "_data_out"}, dout[which], last_good[which]);
        got_data[which].delete();
        got_pe[which].delete();
        exp_data[which].delete();
        exp_pe[which].delete();
    endtask

    initial begin
        logic       bits [$];
        logic       extra [$];
        logic [7:0] d;

        rx    = 4'hF;
        rst_n = 1'b0;
        repeat (3) @(negedge sck);
        for (int i = 0; i < 4; i++) begin
            check_output($sformatf("reset_data_out%0d", i), dout[i], 8'h00);
        end
        check_output("reset_valid", dv, 4'h0);
        check_output("reset_perr", pe, 4'h0);
        check_output("reset_ferr", fe, 4'h0);

        // Frame starts right after reset release, no idle period.
        rst_n = 1'b1;
        make_frame(8'hA5, 1'b0, 1'b0, 1'b1, bits);
        apply_stimulus(0, bits);
        settle(0);
        check_dut(0, "c4_a5");

        // Random back-to-back frames at CPB 4.
        for (int k = 0; k < 4; k++) begin
            d = 8'($urandom);
            make_frame(d, 1'b0, 1'b0, 1'b1, bits);
            apply_stimulus(0, bits);
        end
        settle(0);
        check_dut(0, "c4_rand");

        // Single-cycle bits, explicit pattern then a second frame with no gap.
        bits = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        apply_stimulus(1, bits);
        make_frame(8'($urandom), 1'b0, 1'b0, 1'b1, bits);
        apply_stimulus(1, bits);
        make_frame(8'($urandom), 1'b0, 1'b0, 1'b1, bits);
        apply_stimulus(1, bits);
        settle(1);
        check_output("c1_first_is_6b", exp_data[1][0], 8'h6B);
        check_dut(1, "c1_b2b");

        // Even parity: wrong parity bit, then the correct one, then random.
        bits = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        apply_stimulus(2, bits);
        make_frame(8'h03, 1'b1, 1'b0, 1'b1, bits);
        apply_stimulus(2, bits);
        for (int k = 0; k < 4; k++) begin
            make_frame(8'($urandom), 1'b1, 1'($urandom), 1'b1, bits);
            apply_stimulus(2, bits);
        end
        settle(2);
        check_dut(2, "par");

        // Stop bit low, line held low 30 bit periods, then a good frame.
        make_frame(8'($urandom), 1'b0, 1'b0, 1'b0, bits);
        for (int k = 0; k < 30; k++) bits.push_back(1'b0);
        apply_stimulus(0, bits);
        settle(0);
        check_dut(0, "c4_break");
        make_frame(8'($urandom), 1'b0, 1'b0, 1'b1, bits);
        apply_stimulus(0, bits);
        settle(0);
        check_dut(0, "c4_after_break");

        // One-cycle glitch at CPB 16 must be rejected, then a real frame decodes.
        drive(3, 1'b0, 1);
        rx[3] = 1'b1;
        repeat (40) @(negedge sck);
        check_dut(3, "c16_glitch");
        make_frame(8'($urandom), 1'b0, 1'b0, 1'b1, bits);
        apply_stimulus(3, bits);
        settle(3);
        check_dut(3, "c16_frame");

        // Reset in the middle of the 4th data bit.
        d = 8'($urandom);
        make_frame(d, 1'b0, 1'b0, 1'b1, extra);
        for (int i = 0; i < 4; i++) drive(0, extra[i], cpb_tab[0]);
        drive(0, extra[4], 2);
        rst_n = 1'b0;
        #1;
        check_output("midreset_data_out", dout[0], 8'h00);
        check_output("midreset_valid", dv, 4'h0);
        check_output("midreset_perr", pe, 4'h0);
        check_output("midreset_ferr", fe, 4'h0);
        for (int i = 0; i < 4; i++) last_good[i] = 8'h00;
        rx[0] = 1'b1;
        repeat (3) @(negedge sck);
        rst_n = 1'b1;
        make_frame(8'($urandom), 1'b0, 1'b0, 1'b1, bits);
        apply_stimulus(0, bits);
        settle(0);
        check_dut(0, "c4_after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_gen.md
UART_RX_GEN -- requirements
Module: uart_rx_gen

Interface
- REQ-001 SHALL have parameter DATA_W, default 8, meaning payload bits per frame, legal range 5..9.
- REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, meaning sck cycles per bit period, legal range >= 1.
- REQ-003 SHALL have parameter PARITY_EN, default 0, meaning 1 inserts one parity bit after the payload.
- REQ-004 SHALL have parameter PARITY_ODD, default 0, meaning 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.
- REQ-005 SHALL have port sck, input, 1 bit: the single clock; all logic is rising-edge.
- REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
- REQ-007 SHALL have port RX, input, 1 bit: asynchronous serial line, idle high.
- REQ-008 SHALL have port data_out, output, DATA_W bits: last accepted payload, LSB received first.
- REQ-009 SHALL have port data_valid, output, 1 bit: one-cycle pulse when data_out updates.
- REQ-010 SHALL have port parity_err, output, 1 bit: qualifies data_valid; high when the parity check failed.
- REQ-011 SHALL have port frame_err, output, 1 bit: one-cycle pulse when the stop bit is sampled low.

Function
- REQ-012 SHALL pass RX through a 2-flop synchronizer (reset to 1); all decisions use the synchronized value rxs.
- REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH, driven by a bit-period counter cnt and a bit index idx.
- REQ-014 SHALL, in IDLE with rxs = 0, enter START with cnt = 0.
- REQ-015 SHALL, in START, sample rxs when cnt = (CLKS_PER_BIT-1)/2 (integer division): 0 -> DATA with cnt = 0 and idx = 0; 1 -> IDLE (false start, no output pulse).
- REQ-016 SHALL, in DATA, PARITY and STOP, sample rxs when cnt = CLKS_PER_BIT-1 and reset cnt to 0, giving mid-bit sampling; for CLKS_PER_BIT = 1, it samples every cycle.
- REQ-017 SHALL shift DATA samples in LSB first; after sample idx = DATA_W-1, it goes to PARITY if PARITY_EN, else to STOP.
- REQ-018 SHALL, in PARITY, compare the sample against the XOR of the payload XOR PARITY_ODD, latch a mismatch, then go to STOP.
- REQ-019 SHALL, on a STOP sample of 1, load data_out, pulse data_valid for exactly one cycle, drive parity_err with the latched mismatch (0 when PARITY_EN = 0), and go to IDLE.
- REQ-020 SHALL, on a STOP sample of 0, pulse frame_err for one cycle, hold data_out, keep data_valid at 0, and go to WAIT_HIGH.
- REQ-021 SHALL, in WAIT_HIGH, stay until rxs = 1, then go to IDLE (a break is never decoded as a start).
- REQ-022 SHALL produce data_valid and frame_err in the cycle after the stop-bit sample edge; parity_err is 0 whenever data_valid is 0.
- REQ-023 SHALL allow a start bit to be detected in the cycle right after returning to IDLE (back-to-back frames with one stop bit).
- REQ-024 SHALL ignore RX glitches except at the sample points defined in REQ-015 and REQ-016.

Reset
- REQ-025 SHALL, on rst_n = 0 at any time including mid-frame, immediately force state IDLE, cnt = 0, idx = 0, shift register = 0, data_out = 0, data_valid = 0, parity_err = 0, frame_err = 0, and synchronizer flops = 1.
- REQ-026 SHALL, after rst_n deasserts, need no idle period: the first falling edge of rxs starts a frame.

Structure
- REQ-027 SHALL take the state encoding and the parity-mode constants (PAR_EVEN = 0, PAR_ODD = 1) from shared package uart_pkg, which is reused by the matching transmitter.
- REQ-028 SHALL instantiate one sub-module, uart_sync2 (the 2-flop synchronizer with a reset value parameter); all other logic sits in uart_rx_gen.

Verification
- REQ-029 SHALL cover: CLKS_PER_BIT = 4, DATA_W = 8, no parity; send 0xA5 then stop = 1 -> data_out = 0xA5, one data_valid pulse, parity_err = 0, frame_err = 0.
- REQ-030 SHALL cover: CLKS_PER_BIT = 1, DATA_W = 8; send bits 0,1,1,0,1,0,1,1,0,1 (start, LSB-first payload, stop), then a second frame with no idle gap -> 0x6B first, second frame accepted.
- REQ-031 SHALL cover: PARITY_EN = 1, PARITY_ODD = 0; send 0x03 with parity 1 -> data_valid = 1 with parity_err = 1; resend with parity 0 -> parity_err = 0.
- REQ-032 SHALL cover: a stop bit driven 0 then RX held low for 30 bit periods -> exactly one frame_err pulse, no data_valid, data_out unchanged, and the next valid frame decodes correctly.
- REQ-033 SHALL cover: a 1-cycle low glitch on RX with CLKS_PER_BIT = 16 -> returns to IDLE, no output pulses.
- REQ-034 SHALL cover: rst_n asserted during the 4th data bit -> all outputs 0 at once; a frame sent after release decodes correctly.
